// File: rtl/sprite_anim_addr.sv
// sprite_anim_addr: beam position to sprite ROM address with a tick-paced frame sequencer
module sprite_anim_addr #(
  parameter int SPRITE_W   = 64,
  parameter int SPRITE_H   = 64,
  parameter int NUM_FRAMES = 4,
  parameter int FRAME_HOLD = 6,
  parameter int ADDR_W     = 14,
  localparam int FW = NUM_FRAMES > 1 ? $clog2(NUM_FRAMES) : 1
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              flip,
  input  logic              loop,
  input  logic              anim_start,
  input  logic              frame_tick,
  output logic [ADDR_W-1:0] rom_address,
  output logic              in_sprite,
  output logic [FW-1:0]     frame_idx,
  output logic              anim_done
);
  localparam int HW = $clog2(FRAME_HOLD + 1);
  localparam int XW = $clog2(SPRITE_W);
  localparam logic [10:0] W11 = 11'(SPRITE_W);
  localparam logic [10:0] H11 = 11'(SPRITE_H);
  localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(SPRITE_W * SPRITE_H);
  localparam logic [HW-1:0] HOLD_LAST = HW'(FRAME_HOLD - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(NUM_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, PLAY, HOLD} state_t;

  state_t            state_q;
  logic [HW-1:0]     hold_q;
  logic [FW-1:0]     frame_q;
  logic [ADDR_W-1:0] base_q;
  logic              done_q;
  logic [9:0]        lx_q, ly_q;
  logic              lflip_q;
  logic [ADDR_W-1:0] rom_q, rom_d;
  logic              in_q, in_d;
  logic [10:0]       rel_x, rel_y, col;

  // Position and facing only change at a frame boundary so a frame never tears.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      lx_q    <= '0;
      ly_q    <= '0;
      lflip_q <= 1'b0;
    end else if (frame_tick) begin
      lx_q    <= pos_x;
      ly_q    <= pos_y;
      lflip_q <= flip;
    end
  end

  // Frame sequencer; frame_base tracks frame_idx*W*H by adding one frame size per advance.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      frame_q <= '0;
      base_q  <= '0;
      done_q  <= 1'b0;
    end else if (anim_start) begin
      state_q <= PLAY;
      hold_q  <= '0;
      frame_q <= '0;
      base_q  <= '0;
      done_q  <= 1'b0;
    end else if (state_q == PLAY && frame_tick) begin
      if (hold_q != HOLD_LAST) begin
        hold_q <= hold_q + 1'b1;
      end else begin
        hold_q <= '0;
        if (frame_q != FRAME_LAST) begin
          frame_q <= frame_q + 1'b1;
          base_q  <= base_q + FRAME_SZ;
        end else if (loop) begin
          frame_q <= '0;
          base_q  <= '0;
        end else begin
          state_q <= HOLD;
          done_q  <= 1'b1;
        end
      end
    end
  end

  assign rel_x = {1'b0, draw_x} - {1'b0, lx_q};
  assign rel_y = {1'b0, draw_y} - {1'b0, ly_q};
  assign col   = lflip_q ? (W11 - 11'd1 - rel_x) : rel_x;

  // Negative offsets have bit 10 set, so an unsigned compare alone clips both edges.
  always_comb begin
    in_d  = !rel_x[10] && !rel_y[10] && rel_x < W11 && rel_y < H11;
    rom_d = in_d ? base_q + (ADDR_W'(rel_y) << XW) + ADDR_W'(col) : '0;
  end

  // Register the address so the ROM can sample it on the following negedge.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rom_q <= '0;
      in_q  <= 1'b0;
    end else begin
      rom_q <= rom_d;
      in_q  <= in_d;
    end
  end

  assign rom_address = rom_q;
  assign in_sprite   = in_q;
  assign frame_idx   = frame_q;
  assign anim_done   = done_q;
endmodule

// File: tb/tb_sprite_anim_addr.sv
// tb_sprite_anim_addr: directed and random checks against an arithmetic reference model
module tb_sprite_anim_addr;
  localparam int W = 64, H = 64, N = 4, FH = 6, AW = 14;

  logic          vga_clk = 1'b0;
  logic          reset = 1'b1;
  logic [9:0]    draw_x = '0, draw_y = '0, pos_x = '0, pos_y = '0;
  logic          flip = 1'b0, loop = 1'b0, anim_start = 1'b0, frame_tick = 1'b0;
  logic [AW-1:0] rom_address;
  logic          in_sprite;
  logic [1:0]    frame_idx;
  logic          anim_done;

  int errors = 0, checks = 0;
  int m_lx = 0, m_ly = 0, m_n = 0;
  bit m_flip = 0, m_play = 0, m_done = 0;

  always #5 vga_clk = ~vga_clk;

  sprite_anim_addr #(.SPRITE_W(W), .SPRITE_H(H), .NUM_FRAMES(N), .FRAME_HOLD(FH), .ADDR_W(AW)) dut (
    .vga_clk(vga_clk), .reset(reset), .draw_x(draw_x), .draw_y(draw_y),
    .pos_x(pos_x), .pos_y(pos_y), .flip(flip), .loop(loop),
    .anim_start(anim_start), .frame_tick(frame_tick),
    .rom_address(rom_address), .in_sprite(in_sprite),
    .frame_idx(frame_idx), .anim_done(anim_done)
  );

  function automatic int exp_frame();
    return m_done ? N - 1 : m_play ? (m_n / FH) % N : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input int expv);
    checks++;
    assert (obs === 32'(expv)) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic cyc(input int dx, input int dy, input bit st, input bit tk, input bit rs);
    int ef, ea, rx, ry;
    bit ein;
    draw_x = 10'(dx); draw_y = 10'(dy);
    anim_start = st; frame_tick = tk; reset = rs;
    ef = exp_frame();
    rx = dx - m_lx;
    ry = dy - m_ly;
    ein = !rs && rx >= 0 && rx < W && ry >= 0 && ry < H;
    ea = ein ? (ef * W * H + ry * W + (m_flip ? W - 1 - rx : rx)) % (1 << AW) : 0;
    @(posedge vga_clk);
    if (rs) begin
      m_lx = 0; m_ly = 0; m_flip = 0; m_play = 0; m_done = 0; m_n = 0;
    end else begin
      if (tk) begin
        m_lx = int'(pos_x); m_ly = int'(pos_y); m_flip = flip;
      end
      if (st) begin
        m_play = 1; m_done = 0; m_n = 0;
      end else if (tk && m_play && !m_done) begin
        m_n++;
        if (!loop && m_n % (N * FH) == 0) m_done = 1;
      end
    end
    #1;
    chk("in_sprite", in_sprite, int'(ein));
    chk("rom_address", rom_address, ea);
    chk("frame_idx", frame_idx, exp_frame());
    chk("anim_done", anim_done, int'(m_done));
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) begin
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("reset_frame", frame_idx, 0);
    chk("reset_addr", rom_address, 0);
    pos_x = 10'd100; pos_y = 10'd50;
    cyc(0, 0, 0, 1, 0);
    for (int x = 100; x <= 164; x++) cyc(x, 50, 0, 0, 0);
    chk("sweep_edge_out", in_sprite, 0);
    cyc(100, 50, 0, 0, 0);
    chk("sweep_first", rom_address, 0);
    cyc(163, 50, 0, 0, 0);
    chk("sweep_last", rom_address, 63);
    flip = 1'b1;
    cyc(0, 0, 0, 1, 0);
    cyc(100, 51, 0, 0, 0);
    chk("flip_left", rom_address, 127);
    cyc(163, 51, 0, 0, 0);
    chk("flip_right", rom_address, 64);
    flip = 1'b0;
    cyc(0, 0, 0, 1, 0);
    loop = 1'b0;
    cyc(0, 0, 1, 0, 0);
    ticks(18);
    chk("oneshot_f3", frame_idx, 3);
    chk("oneshot_not_done", anim_done, 0);
    ticks(6);
    chk("oneshot_done", anim_done, 1);
    ticks(5);
    chk("oneshot_hold", frame_idx, 3);
    cyc(100, 50, 0, 0, 0);
    chk("oneshot_px00", rom_address, 12288);
    loop = 1'b1;
    cyc(0, 0, 1, 0, 0);
    chk("restart_done_low", anim_done, 0);
    ticks(24);
    chk("loop_wrap", frame_idx, 0);
    ticks(12);
    chk("loop_f2", frame_idx, 2);
    cyc(0, 0, 1, 1, 0);
    chk("collide_f0", frame_idx, 0);
    ticks(5);
    chk("collide_cnt0", frame_idx, 0);
    ticks(1);
    chk("collide_adv", frame_idx, 1);
    pos_x = 10'd300;
    cyc(110, 50, 0, 0, 0);
    chk("no_tick_move", rom_address, 4096 + 10);
    pos_x = 10'd620;
    cyc(0, 0, 0, 1, 0);
    cyc(639, 50, 0, 0, 0);
    chk("clip_in", in_sprite, 1);
    cyc(0, 51, 0, 0, 0);
    chk("clip_nowrap", in_sprite, 0);
    cyc(0, 0, 1, 0, 0);
    ticks(12);
    chk("pre_reset_f2", frame_idx, 2);
    cyc(0, 0, 0, 1, 1);
    chk("midplay_reset", frame_idx, 0);
    ticks(8);
    chk("idle_no_adv", frame_idx, 0);
    for (int i = 0; i < 4000; i++) begin
      int dx, dy;
      if ($urandom_range(0, 3) == 0) begin
        pos_x = 10'($urandom_range(0, 700));
        pos_y = 10'($urandom_range(0, 500));
        flip  = 1'($urandom);
      end
      if ($urandom_range(0, 99) == 0) loop = 1'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        dx = m_lx + int'($urandom_range(0, W + 8)) - 4;
        dy = m_ly + int'($urandom_range(0, H + 8)) - 4;
        if (dx < 0) dx = 0;
        if (dx > 799) dx = 799;
        if (dy < 0) dy = 0;
        if (dy > 524) dy = 524;
      end else begin
        dx = int'($urandom_range(0, 799));
        dy = int'($urandom_range(0, 524));
      end
      cyc(dx, dy, $urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 499) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
